key_debounce: RTL and testbench

Front-end conditioner for the board push-buttons that feed the shift register stage. It synchronises each raw active-low key into the clock domain and debounces it with a per-key stability counter. It then emits single-cycle press and release pulses plus a debounced level, with optional hold-to-repeat so a held shift key keeps stepping the LEDs. Its press outputs drive the shift stage's right/left shift requests directly, replacing raw key edges.

---
 rtl/key_debounce_if.sv | 23 ++
 rtl/key_debounce.sv | 209 ++++++++++++++++++++
 tb/tb_key_debounce.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/key_debounce_if.sv
// Key bus: raw active-low buttons in, debounced level and one-clock event pulses out.
interface key_debounce_if #(
    parameter int N_KEYS = 2
);
    logic [N_KEYS-1:0] key_n;
    logic [N_KEYS-1:0] level;
    logic [N_KEYS-1:0] press;
    logic [N_KEYS-1:0] key_release;

    modport master (
        output key_n,
        input  level,
        input  press,
        input  key_release
    );

    modport slave (
        input  key_n,
        output level,
        output press,
        output key_release
    );
endinterface

// File: rtl/key_debounce.sv
// Per-key synchroniser, stability-counter debouncer and optional hold-to-repeat,
// producing a debounced level plus one-clock press/release pulses.
module key_debounce #(
    parameter int N_KEYS        = 2,
    parameter int STABLE_CYCLES = 50000,
    parameter int REPEAT_DELAY  = 0,
    parameter int REPEAT_PERIOD = 10000000
) (
    input  logic          clk,
    input  logic          key0_rst,
    key_debounce_if.slave kb
);

    localparam int CW      = (STABLE_CYCLES < 2) ? 1 : $clog2(STABLE_CYCLES + 1);
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW      = (RPT_MAX < 2) ? 1 : $clog2(RPT_MAX + 1);
    localparam bit RPT_EN  = (REPEAT_DELAY != 0);

    localparam logic [CW-1:0] STABLE_C     = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_ZERO     = CW'(0);
    localparam logic [CW-1:0] CNT_ONE      = CW'(1);
    localparam logic [RW-1:0] RPT_DELAY_C  = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] RPT_PERIOD_C = RW'(REPEAT_PERIOD);
    localparam logic [RW-1:0] RPT_ZERO     = RW'(0);
    localparam logic [RW-1:0] RPT_ONE      = RW'(1);

    typedef enum logic [1:0] {
        ST_RELEASED  = 2'd0,
        ST_PRESSING  = 2'd1,
        ST_PRESSED   = 2'd2,
        ST_RELEASING = 2'd3
    } state_e;

    logic [N_KEYS-1:0] level_s;
    logic [N_KEYS-1:0] press_s;
    logic [N_KEYS-1:0] release_s;

    assign kb.level       = level_s;
    assign kb.press       = press_s;
    assign kb.key_release = release_s;

    for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
        logic          sync1_q;
        logic          sync2_q;
        logic          key_low_s;
        state_e        state_q;
        state_e        state_d;
        logic [CW-1:0] cnt_q;
        logic [CW-1:0] cnt_d;
        logic [CW-1:0] cnt_inc_s;
        logic [RW-1:0] rpt_q;
        logic [RW-1:0] rpt_d;
        logic [RW-1:0] rpt_inc_s;
        logic          rpt_first_q;
        logic          rpt_first_d;
        logic          rpt_hit_s;
        logic          rpt_run_s;
        logic          start_rpt_s;
        logic          level_q;
        logic          level_d;
        logic          press_q;
        logic          press_d;
        logic          release_q;
        logic          release_d;

        // Two-flop synchroniser; idle value is "released" so reset never looks like a press
        always_ff @(posedge clk or negedge key0_rst) begin
            if (!key0_rst) begin
                sync1_q <= 1'b1;
                sync2_q <= 1'b1;
            end else begin
                sync1_q <= kb.key_n[i];
                sync2_q <= sync1_q;
            end
        end

        assign key_low_s = ~sync2_q;
        assign cnt_inc_s = cnt_q + CNT_ONE;
        assign rpt_inc_s = rpt_q + RPT_ONE;
        assign rpt_run_s = (state_q == ST_PRESSED) || (state_q == ST_RELEASING);
        // The first repeat waits REPEAT_DELAY, later ones REPEAT_PERIOD
        assign rpt_hit_s = rpt_first_q ? (rpt_inc_s == RPT_DELAY_C) : (rpt_inc_s == RPT_PERIOD_C);

        // Debounce FSM, stability counter and repeat timer next-state logic
        always_comb begin
            state_d     = state_q;
            cnt_d       = cnt_q;
            rpt_d       = rpt_q;
            rpt_first_d = rpt_first_q;
            level_d     = level_q;
            press_d     = 1'b0;
            release_d   = 1'b0;
            start_rpt_s = 1'b0;

            // The counter includes the sample that left the stable state, so
            // the level flips on exactly the STABLE_CYCLES-th differing sample.
            case (state_q)
                ST_RELEASED: begin
                    cnt_d = CNT_ZERO;
                    if (key_low_s) begin
                        if (CNT_ONE == STABLE_C) begin
                            state_d     = ST_PRESSED;
                            level_d     = 1'b1;
                            press_d     = 1'b1;
                            start_rpt_s = 1'b1;
                        end else begin
                            state_d = ST_PRESSING;
                            cnt_d   = CNT_ONE;
                        end
                    end else begin
                        state_d = ST_RELEASED;
                    end
                end
                ST_PRESSING: begin
                    if (!key_low_s) begin
                        state_d = ST_RELEASED;
                        cnt_d   = CNT_ZERO;
                    end else if (cnt_inc_s == STABLE_C) begin
                        state_d     = ST_PRESSED;
                        cnt_d       = CNT_ZERO;
                        level_d     = 1'b1;
                        press_d     = 1'b1;
                        start_rpt_s = 1'b1;
                    end else begin
                        cnt_d = cnt_inc_s;
                    end
                end
                ST_PRESSED: begin
                    cnt_d = CNT_ZERO;
                    if (!key_low_s) begin
                        if (CNT_ONE == STABLE_C) begin
                            state_d   = ST_RELEASED;
                            level_d   = 1'b0;
                            release_d = 1'b1;
                        end else begin
                            state_d = ST_RELEASING;
                            cnt_d   = CNT_ONE;
                        end
                    end else begin
                        state_d = ST_PRESSED;
                    end
                end
                ST_RELEASING: begin
                    if (key_low_s) begin
                        state_d = ST_PRESSED;
                        cnt_d   = CNT_ZERO;
                    end else if (cnt_inc_s == STABLE_C) begin
                        state_d   = ST_RELEASED;
                        cnt_d     = CNT_ZERO;
                        level_d   = 1'b0;
                        release_d = 1'b1;
                    end else begin
                        cnt_d = cnt_inc_s;
                    end
                end
                default: begin
                    state_d = ST_RELEASED;
                    cnt_d   = CNT_ZERO;
                    level_d = 1'b0;
                end
            endcase

            // Release wins over a coincident repeat and clears the repeat timer
            if (start_rpt_s) begin
                rpt_d       = RPT_ZERO;
                rpt_first_d = 1'b1;
            end else if (release_d) begin
                rpt_d       = RPT_ZERO;
                rpt_first_d = 1'b0;
            end else if (RPT_EN && rpt_run_s) begin
                if (rpt_hit_s) begin
                    press_d     = 1'b1;
                    rpt_d       = RPT_ZERO;
                    rpt_first_d = 1'b0;
                end else begin
                    rpt_d = rpt_inc_s;
                end
            end else begin
                rpt_d = rpt_q;
            end
        end

        // Channel state and registered outputs
        always_ff @(posedge clk or negedge key0_rst) begin
            if (!key0_rst) begin
                state_q     <= ST_RELEASED;
                cnt_q       <= CNT_ZERO;
                rpt_q       <= RPT_ZERO;
                rpt_first_q <= 1'b0;
                level_q     <= 1'b0;
                press_q     <= 1'b0;
                release_q   <= 1'b0;
            end else begin
                state_q     <= state_d;
                cnt_q       <= cnt_d;
                rpt_q       <= rpt_d;
                rpt_first_q <= rpt_first_d;
                level_q     <= level_d;
                press_q     <= press_d;
                release_q   <= release_d;
            end
        end

        assign level_s[i]   = level_q;
        assign press_s[i]   = press_q;
        assign release_s[i] = release_q;
    end

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce: vector table on a non-repeating instance,
// hand-written repeat and reset sequences on a repeating instance.
module tb_key_debounce;

    localparam int N = 2;

    typedef struct {
        logic [1:0] kn;
        logic [1:0] lvl;
        logic [1:0] prs;
        logic [1:0] rel;
    } vec_t;

    logic clk = 1'b0;
    logic rst_a_n;
    logic rst_b_n;
    int   checks = 0;
    int   failures = 0;
    int   n_press;
    int   n_rel;
    vec_t vecs[$];

    key_debounce_if #(.N_KEYS(N)) kb_a ();
    key_debounce_if #(.N_KEYS(N)) kb_b ();

    key_debounce #(
        .N_KEYS(N), .STABLE_CYCLES(4), .REPEAT_DELAY(0), .REPEAT_PERIOD(1)
    ) dut_a (
        .clk(clk), .key0_rst(rst_a_n), .kb(kb_a.slave)
    );

    key_debounce #(
        .N_KEYS(N), .STABLE_CYCLES(4), .REPEAT_DELAY(8), .REPEAT_PERIOD(3)
    ) dut_b (
        .clk(clk), .key0_rst(rst_b_n), .kb(kb_b.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic seg(input int n, input logic [1:0] kn, input logic [1:0] lvl,
                       input logic [1:0] prs, input logic [1:0] rel);
        vec_t v;
        v.kn  = kn;
        v.lvl = lvl;
        v.prs = prs;
        v.rel = rel;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    initial begin
        logic [1:0] ep;
        logic [1:0] el;
        logic [1:0] er;

        rst_a_n     = 1'b0;
        rst_b_n     = 1'b0;
        kb_a.key_n  = 2'b11;
        kb_b.key_n  = 2'b11;

        // idle
        seg(3,  2'b11, 2'b00, 2'b00, 2'b00);
        // key0 held 20 clocks: press 5 after first low sample
        seg(5,  2'b10, 2'b00, 2'b00, 2'b00);
        seg(1,  2'b10, 2'b01, 2'b01, 2'b00);
        seg(14, 2'b10, 2'b01, 2'b00, 2'b00);
        // key0 released: release 5 after first high sample
        seg(5,  2'b11, 2'b01, 2'b00, 2'b00);
        seg(1,  2'b11, 2'b00, 2'b00, 2'b01);
        seg(2,  2'b11, 2'b00, 2'b00, 2'b00);
        // key0 glitch of 3 clocks: nothing happens
        seg(3,  2'b10, 2'b00, 2'b00, 2'b00);
        seg(8,  2'b11, 2'b00, 2'b00, 2'b00);
        // key1 bounce: low2 high1 low3 high2 then low; press 5 after final fall
        seg(2,  2'b01, 2'b00, 2'b00, 2'b00);
        seg(1,  2'b11, 2'b00, 2'b00, 2'b00);
        seg(3,  2'b01, 2'b00, 2'b00, 2'b00);
        seg(2,  2'b11, 2'b00, 2'b00, 2'b00);
        seg(5,  2'b01, 2'b00, 2'b00, 2'b00);
        seg(1,  2'b01, 2'b10, 2'b10, 2'b00);
        seg(6,  2'b01, 2'b10, 2'b00, 2'b00);
        // key1 release
        seg(5,  2'b11, 2'b10, 2'b00, 2'b00);
        seg(1,  2'b11, 2'b00, 2'b00, 2'b10);
        seg(2,  2'b11, 2'b00, 2'b00, 2'b00);
        // both keys pressed on the same clock
        seg(5,  2'b00, 2'b00, 2'b00, 2'b00);
        seg(1,  2'b00, 2'b11, 2'b11, 2'b00);
        seg(4,  2'b00, 2'b11, 2'b00, 2'b00);
        // staggered release: key0 first, key1 three clocks later
        seg(3,  2'b01, 2'b11, 2'b00, 2'b00);
        seg(2,  2'b11, 2'b11, 2'b00, 2'b00);
        seg(1,  2'b11, 2'b10, 2'b00, 2'b01);
        seg(2,  2'b11, 2'b10, 2'b00, 2'b00);
        seg(1,  2'b11, 2'b00, 2'b00, 2'b10);
        seg(4,  2'b11, 2'b00, 2'b00, 2'b00);

        @(negedge clk);
        @(negedge clk);
        chk("reset_a_level",   kb_a.level,       2'b00);
        chk("reset_a_press",   kb_a.press,       2'b00);
        chk("reset_a_release", kb_a.key_release, 2'b00);
        chk("reset_b_level",   kb_b.level,       2'b00);
        rst_a_n = 1'b1;
        rst_b_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            kb_a.key_n = vecs[i].kn;
            @(negedge clk);
            chk($sformatf("vec%0d_level", i),   kb_a.level,       vecs[i].lvl);
            chk($sformatf("vec%0d_press", i),   kb_a.press,       vecs[i].prs);
            chk($sformatf("vec%0d_release", i), kb_a.key_release, vecs[i].rel);
        end

        // Repeat: key0 held 30 clocks; press at 5, 13, then every 3 until release at 35
        n_press = 0;
        n_rel   = 0;
        for (int r = 0; r < 46; r++) begin
            kb_b.key_n = (r < 30) ? 2'b10 : 2'b11;
            @(negedge clk);
            ep = {1'b0, (r == 5) || (r >= 13 && r <= 34 && ((r - 13) % 3) == 0)};
            el = {1'b0, (r >= 5 && r <= 34)};
            er = {1'b0, (r == 35)};
            chk($sformatf("rpt%0d_press", r),   kb_b.press,       ep);
            chk($sformatf("rpt%0d_level", r),   kb_b.level,       el);
            chk($sformatf("rpt%0d_release", r), kb_b.key_release, er);
            if (kb_b.press[0]) n_press++;
            if (kb_b.key_release[0]) n_rel++;
        end
        checks++;
        if (n_press != 9) begin
            failures++;
            $display("FAIL rpt_press_count: got %0d want 9", n_press);
        end
        checks++;
        if (n_rel != 1) begin
            failures++;
            $display("FAIL rpt_release_count: got %0d want 1", n_rel);
        end

        // Reset while pressed with a repeat pulse on the outputs
        for (int r = 0; r < 14; r++) begin
            kb_b.key_n = 2'b10;
            @(negedge clk);
            chk($sformatf("pre%0d_press", r), kb_b.press, (r == 5 || r == 13) ? 2'b01 : 2'b00);
            chk($sformatf("pre%0d_level", r), kb_b.level, (r >= 5) ? 2'b01 : 2'b00);
        end
        #1 rst_b_n = 1'b0;
        #1;
        chk("async_rst_level",   kb_b.level,       2'b00);
        chk("async_rst_press",   kb_b.press,       2'b00);
        chk("async_rst_release", kb_b.key_release, 2'b00);
        @(negedge clk);
        @(negedge clk);
        chk("in_rst_level", kb_b.level, 2'b00);
        chk("in_rst_press", kb_b.press, 2'b00);
        rst_b_n = 1'b1;
        for (int r = 0; r < 12; r++) begin
            @(negedge clk);
            chk($sformatf("post%0d_press", r),   kb_b.press,       (r == 5) ? 2'b01 : 2'b00);
            chk($sformatf("post%0d_level", r),   kb_b.level,       (r >= 5) ? 2'b01 : 2'b00);
            chk($sformatf("post%0d_release", r), kb_b.key_release, 2'b00);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
